sar_adc: RTL and testbench

// - Digitises the real-valued analog output of the DUT model (vout) into a BITS-wide code.
// - Uses an 8-step successive-approximation conversion (default BITS=8).
// - Sits directly downstream of the analog DUT and gives the digital domain a sampled, handshaked result.
// - Contains an internal real-valued DAC model for the trial voltages.
//

---
 rtl/sar_adc_pkg.sv | 20 ++
 rtl/sar_adc_dac.sv | 21 ++
 rtl/sar_adc.sv | 127 ++++++++++++
 tb/tb_sar_adc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg
//   Shared declarations for the successive-approximation ADC slice.
//   - sar_state_t   : converter FSM states
//   - code_to_volts : ideal DAC transfer function, code * vref / 2**bits.
//                     The DAC model uses it, and benches can reuse it as a golden reference.
`timescale 1ns/1ps
package sar_adc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } sar_state_t;

  function automatic real code_to_volts(int code, int bits, real vref);
    real full_scale;
    full_scale = real'(longint'(1) << bits);
    return real'(code) * vref / full_scale;
  endfunction

endpackage

// File: rtl/sar_adc_dac.sv
// sar_dac_model
//   Combinational, real-valued model of the ADC's internal trial DAC.
//   Ports:
//     code  in   BITS  DAC input code
//     vout  out  real  code * VREF / 2**BITS
`timescale 1ns/1ps
module sar_dac_model
  import sar_adc_pkg::*;
#(
  parameter int  BITS = 8,
  parameter real VREF = 4.0
) (
  input  logic [BITS-1:0] code,
  output real             vout
);

  always_comb begin
    vout = code_to_volts(int'(code), BITS, VREF);
  end

endmodule

// File: rtl/sar_adc.sv
// sar_adc
//   Successive-approximation ADC. It digitises a real-valued analog input into a
//   BITS-wide code. Each conversion resolves one bit per clock, from the MSB down.
//   Ports:
//     clk    in   1     clock, rising edge
//     rst_n  in   1     asynchronous active-low reset
//     vin    in   real  analog input, captured only when a start is accepted
//     start  in   1     conversion request, level-sampled while idle
//     busy   out  1     conversion in progress
//     done   out  1     one-cycle pulse when code/ovr update
//     code   out  BITS  last result, held until the next done
//     ovr    out  1     last sample was outside [0, VREF)
//     vdac   out  real  current DAC trial voltage (0.0 while idle)
`timescale 1ns/1ps
module sar_adc
  import sar_adc_pkg::*;
#(
  parameter int  BITS = 8,
  parameter real VREF = 4.0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  real             vin,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] code,
  output logic            ovr,
  output real             vdac
);

  localparam int IW = $clog2(BITS);

  sar_state_t      r_state, w_state_next;
  real             r_vhold, w_vhold_next;
  logic [BITS-1:0] r_trial, w_trial_next;
  logic [IW-1:0]   r_bit_idx, w_bit_idx_next;
  logic            r_ovr_pend, w_ovr_pend_next;
  logic [BITS-1:0] r_code, w_code_next;
  logic            r_ovr, w_ovr_next;
  logic            r_done, w_done_next;

  logic [BITS-1:0] w_cand;
  logic [BITS-1:0] w_dac_code;
  real             w_vdac;
  logic            w_keep;

  // The candidate is the bits decided so far plus the bit under test.
  assign w_cand     = r_trial | ({{(BITS-1){1'b0}}, 1'b1} << r_bit_idx);
  // Driving code 0 while idle makes the DAC read 0.0 V.
  assign w_dac_code = (r_state == CONVERT) ? w_cand : '0;

  sar_dac_model #(
    .BITS (BITS),
    .VREF (VREF)
  ) u_dac (
    .code (w_dac_code),
    .vout (w_vdac)
  );

  // The >= comparison sends ties to the upper code.
  assign w_keep = (r_vhold >= w_vdac);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_vhold    <= 0.0;
      r_trial    <= '0;
      r_bit_idx  <= '0;
      r_ovr_pend <= 1'b0;
      r_code     <= '0;
      r_ovr      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_vhold    <= w_vhold_next;
      r_trial    <= w_trial_next;
      r_bit_idx  <= w_bit_idx_next;
      r_ovr_pend <= w_ovr_pend_next;
      r_code     <= w_code_next;
      r_ovr      <= w_ovr_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_vhold_next    = r_vhold;
    w_trial_next    = r_trial;
    w_bit_idx_next  = r_bit_idx;
    w_ovr_pend_next = r_ovr_pend;
    w_code_next     = r_code;
    w_ovr_next      = r_ovr;
    w_done_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = CONVERT;
          w_vhold_next    = vin;
          w_ovr_pend_next = (vin < 0.0) || (vin >= VREF);
          w_trial_next    = '0;
          w_bit_idx_next  = IW'(BITS - 1);
        end
      end
      CONVERT: begin
        // start is deliberately ignored here, and vhold stays frozen.
        w_trial_next = w_keep ? w_cand : r_trial;
        if (r_bit_idx == '0) begin
          w_state_next = IDLE;
          w_code_next  = w_trial_next;
          w_ovr_next   = r_ovr_pend;
          w_done_next  = 1'b1;
        end else begin
          w_bit_idx_next = r_bit_idx - IW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy = (r_state == CONVERT);
  assign done = r_done;
  assign code = r_code;
  assign ovr  = r_ovr;
  assign vdac = w_vdac;

endmodule

// File: tb/tb_sar_adc.sv
`timescale 1ns/1ps
module tb_sar_adc;
  import sar_adc_pkg::*;

  logic       clk;
  logic       rst_n;
  real        vin;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] code;
  logic       ovr;
  real        vdac;

  int total;
  int bad;

  sar_adc #(.BITS(8), .VREF(4.0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vin   (vin),
    .start (start),
    .busy  (busy),
    .done  (done),
    .code  (code),
    .ovr   (ovr),
    .vdac  (vdac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 ms watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    real        vin;
    logic [7:0] code;
    logic       ovr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic chk_r(input string name, input real got, input real exp);
    total++;
    if ((got - exp > 1.0e-9) || (exp - got > 1.0e-9)) begin
      bad++;
      $display("FAIL %s: got=%f expected=%f", name, got, exp);
    end else begin
      $display("ok   %s: %f", name, got);
    end
  endtask

  // Start one conversion and wait (bounded) for done.
  // lat counts rising edges from the accept edge (1) to the done edge inclusive.
  task automatic convert(input real v, output int lat, output logic busy_at_done);
    int n;
    @(negedge clk);
    vin   = v;
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      lat++;
      n++;
    end
    busy_at_done = busy;
  endtask

  initial begin
    int         lat;
    logic       bsy;
    int         ndone;
    logic [7:0] got_code;
    int         dtimes[$];

    total = 0;
    bad   = 0;
    vin   = 0.0;
    start = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{"mid_2p0",     2.0,      8'h80, 1'b0};
    vecs[1] = '{"grid_1p0",    1.0,      8'h40, 1'b0};
    vecs[2] = '{"grid_3p0",    3.0,      8'hC0, 1'b0};
    vecs[3] = '{"grid_3p99",   3.99,     8'hFF, 1'b0};
    vecs[4] = '{"below_lsb",   0.0155,   8'h00, 1'b0};
    vecs[5] = '{"one_lsb",     0.015625, 8'h01, 1'b0};
    vecs[6] = '{"neg_0p5",    -0.5,      8'h00, 1'b1};
    vecs[7] = '{"over_5p0",    5.0,      8'hFF, 1'b1};
    vecs[8] = '{"clear_ovr",   2.0,      8'h80, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_ovr",  32'(ovr),  32'd0);
    chk_r("rst_vdac", vdac, 0.0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven conversions
    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].vin, lat, bsy);
      chk({vecs[i].name, "_timeout"}, 32'(done), 32'd1);
      chk({vecs[i].name, "_code"}, 32'(code), 32'(vecs[i].code));
      chk({vecs[i].name, "_ovr"},  32'(ovr),  32'(vecs[i].ovr));
      chk({vecs[i].name, "_lat"},  32'(lat),  32'd9);
      chk({vecs[i].name, "_busy_at_done"}, 32'(bsy), 32'd0);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
      chk({vecs[i].name, "_code_held"}, 32'(code), 32'(vecs[i].code));
    end

    // Start while busy is ignored, vin change mid-conversion has no effect
    @(negedge clk);
    vin   = 1.0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk_r("ign_vdac_e0", vdac, code_to_volts(128, 8, 4.0));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_r("ign_vdac_e1", vdac, code_to_volts(64, 8, 4.0));
    @(posedge clk);
    @(negedge clk);
    vin   = 3.0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone    = 0;
    got_code = 8'h00;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        got_code = code;
      end
    end
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_code", 32'(got_code), 32'h40);
    chk_r("ign_vdac_idle", vdac, 0.0);

    // Reset mid-conversion
    @(negedge clk);
    vin   = 3.0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_code", 32'(code), 32'd0);
    chk_r("mid_rst_vdac", vdac, 0.0);
    @(negedge clk);
    rst_n = 1'b1;
    convert(2.0, lat, bsy);
    chk("after_rst_code", 32'(code), 32'h80);
    chk("after_rst_lat",  32'(lat),  32'd9);
    @(posedge clk);
    #1;

    // Back-to-back with start held high
    @(negedge clk);
    vin   = 2.0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dtimes.push_back(k);
        chk("b2b_code", 32'(code), 32'h80);
      end
      chk("b2b_busy_vs_done", 32'(busy), 32'(!done));
    end
    chk("b2b_done_count", 32'(dtimes.size()), 32'd4);
    if (dtimes.size() >= 1) chk("b2b_first_done", 32'(dtimes[0]), 32'd8);
    for (int j = 1; j < dtimes.size(); j++) begin
      chk("b2b_period", 32'(dtimes[j] - dtimes[j-1]), 32'd9);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
